// File: rtl/cnt_updown_mode.sv
// Loadable up/down/shift counter with programmable limit, step, wrap/saturate,
// terminal-count pulse and sticky overflow. Optional prescaler: CNT_PRESCALER_EN.
module cnt_updown_mode #(
    parameter int unsigned N     = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned PRESC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] R,
    input  logic         L,
    input  logic         E,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    input  logic         sat,
    input  logic         clr_ovf,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         ovf
);

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,
        MODE_DN  = 2'b01,
        MODE_SHL = 2'b10,
        MODE_SHR = 2'b11
    } mode_e;

    localparam logic [N:0]   STEP_X = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N = N'(STEP);

    if (STEP < 1 || PRESC < 1) begin : g_bad_param
        $error("cnt_updown_mode: STEP and PRESC must be >= 1");
    end

    mode_e        op;
    logic [N:0]   q_x;
    logic [N:0]   lim_x;
    logic [N:0]   sum;
    logic [N:0]   shl;
    logic [N-1:0] diff;
    logic [N-1:0] nxt;
    logic         evt;
    logic         step_go;

    assign op    = mode_e'(mode);
    assign q_x   = {1'b0, Q};
    assign lim_x = {1'b0, limit};
    assign sum   = q_x + STEP_X;
    assign shl   = {Q, 1'b0};
    assign diff  = Q - STEP_N;

    always_comb begin
        nxt = Q;
        evt = 1'b0;
        unique case (op)
            MODE_UP: begin
                evt = (sum > lim_x);
                nxt = evt ? (sat ? limit : '0) : sum[N-1:0];
            end
            MODE_DN: begin
                evt = (q_x < STEP_X);
                nxt = evt ? (sat ? '0 : limit) : diff;
            end
            MODE_SHL: begin
                evt = Q[N-1] | (shl > lim_x);
                nxt = evt ? (sat ? limit : '0) : shl[N-1:0];
            end
            MODE_SHR: begin
                evt = (Q == '0);
                nxt = evt ? (sat ? '0 : limit) : {1'b0, Q[N-1:1]};
            end
        endcase
    end

`ifdef CNT_PRESCALER_EN
    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);

    logic [PW-1:0] pre;

    // Only the cycle the prescaler sits at its last value produces a step.
    assign step_go = E && (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (L) begin
            pre <= '0;
        end else if (E) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end
`else
    assign step_go = E;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (L) begin
                Q  <= R;
                tc <= 1'b0;
            end else if (step_go) begin
                Q  <= nxt;
                tc <= evt;
            end else begin
                tc <= 1'b0;
            end
            // A boundary event sets ovf even when clr_ovf is asserted alongside it.
            ovf <= (!L && step_go && evt) | (ovf & ~clr_ovf);
        end
    end

endmodule

// File: tb/tb_cnt_updown_mode.sv
// Directed self-checking bench for cnt_updown_mode (N=8, STEP=1, PRESC=4).
// Prescaler vectors run only when CNT_PRESCALER_EN is defined.
module tb_cnt_updown_mode;

    logic       clk;
    logic       rst_n;
    logic [7:0] R;
    logic       L;
    logic       E;
    logic [1:0] mode;
    logic [7:0] limit;
    logic       sat;
    logic       clr_ovf;
    logic [7:0] Q;
    logic       tc;
    logic       ovf;

    int unsigned n_vec;
    int unsigned n_err;

    cnt_updown_mode #(.N(8), .STEP(1), .PRESC(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .R       (R),
        .L       (L),
        .E       (E),
        .mode    (mode),
        .limit   (limit),
        .sat     (sat),
        .clr_ovf (clr_ovf),
        .Q       (Q),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        L = 1'b1; E = 1'b0; R = v;
        tick();
        L = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic [7:0] eq, input logic etc, input logic eovf);
        check({tag, ".Q"}, Q, eq);
        check({tag, ".tc"}, tc, etc);
        check({tag, ".ovf"}, ovf, eovf);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; R = '0; L = 1'b0; E = 1'b0; mode = 2'b00;
        limit = 8'hFF; sat = 1'b0; clr_ovf = 1'b0;
        #12;
        chk3("rst0", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: reset mid-count, then load
        load(8'h36);
        mode = 2'b00; limit = 8'hFF; E = 1'b1;
        tick();
        check("pre_rst.Q", Q, 8'h37);
        #3 rst_n = 1'b0;
        #1 chk3("async_rst", 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        E = 1'b0;
        load(8'h05);
        chk3("load5", 8'h05, 1'b0, 1'b0);

        // 2: wrap up
        limit = 8'd9; sat = 1'b0; mode = 2'b00;
        load(8'd8);
        E = 1'b1;
        tick(); chk3("wrapup1", 8'd9, 1'b0, 1'b0);
        tick(); chk3("wrapup2", 8'd0, 1'b1, 1'b1);
        tick(); chk3("wrapup3", 8'd1, 1'b0, 1'b1);
        E = 1'b0;

        // 3: saturate down
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("clr1.ovf", ovf, 1'b0);
        sat = 1'b1; mode = 2'b01;
        load(8'd1);
        E = 1'b1;
        tick(); chk3("satdn1", 8'd0, 1'b0, 1'b0);
        tick(); chk3("satdn2", 8'd0, 1'b1, 1'b1);
        tick(); chk3("satdn3", 8'd0, 1'b1, 1'b1);
        E = 1'b0;
        tick(); chk3("hold", 8'd0, 1'b0, 1'b1);

        // 4: shifts
        limit = 8'hFF; sat = 1'b0; mode = 2'b10;
        load(8'h41);
        E = 1'b1;
        tick(); check("shl1.Q", Q, 8'h82); check("shl1.tc", tc, 1'b0);
        tick(); check("shl2.Q", Q, 8'h00); check("shl2.tc", tc, 1'b1);
        mode = 2'b11; sat = 1'b1;
        tick(); check("shr_sat.Q", Q, 8'h00); check("shr_sat.tc", tc, 1'b1);
        sat = 1'b0;
        tick(); check("shr_wrap.Q", Q, 8'hFF); check("shr_wrap.tc", tc, 1'b1);
        tick(); check("shr_plain.Q", Q, 8'h7F); check("shr_plain.tc", tc, 1'b0);
        mode = 2'b10; limit = 8'h20;
        E = 1'b0; load(8'h11);
        E = 1'b1;
        tick(); check("shl_lim.Q", Q, 8'h00); check("shl_lim.tc", tc, 1'b1);
        E = 1'b0;

        // 5: priority and ovf clear
        mode = 2'b00; limit = 8'hFF;
        L = 1'b1; E = 1'b1; R = 8'h20;
        tick(); L = 1'b0; E = 1'b0;
        check("prio.Q", Q, 8'h20); check("prio.tc", tc, 1'b0);
        clr_ovf = 1'b1; tick();
        check("clr2.ovf", ovf, 1'b0);
        limit = 8'h20; E = 1'b1;
        tick(); E = 1'b0;
        chk3("set_wins", 8'h00, 1'b1, 1'b1);
        tick(); clr_ovf = 1'b0;
        chk3("clr3", 8'h00, 1'b0, 1'b0);

        // boundaries: limit=0, Q above limit
        limit = 8'd0; mode = 2'b00; sat = 1'b0; E = 1'b1;
        tick(); chk3("lim0_up", 8'd0, 1'b1, 1'b1);
        mode = 2'b01; limit = 8'd0;
        tick(); check("lim0_dn.Q", Q, 8'd0); check("lim0_dn.tc", tc, 1'b1);
        E = 1'b0; limit = 8'd9;
        load(8'h50);
        check("ld_above.Q", Q, 8'h50);
        E = 1'b1;
        tick(); check("dn_above.Q", Q, 8'h4F); check("dn_above.tc", tc, 1'b0);
        mode = 2'b00; sat = 1'b1;
        tick(); check("up_above.Q", Q, 8'd9); check("up_above.tc", tc, 1'b1);
        sat = 1'b0; limit = 8'd20;
        tick(); check("up_plain.Q", Q, 8'd10); check("up_plain.tc", tc, 1'b0);
        E = 1'b0;

`ifdef CNT_PRESCALER_EN
        // 6: prescaler
        begin
            logic [7:0] exp_q [8];
            exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
            limit = 8'hFF; mode = 2'b00;
            load(8'd0);
            E = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                check($sformatf("presc%0d.Q", i + 1), Q, exp_q[i]);
            end
            tick(); tick();
            L = 1'b1; R = 8'd2; tick(); L = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                check($sformatf("presc_ld%0d.Q", i + 1), Q, (i == 3) ? 8'd3 : 8'd2);
            end
            E = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
